// File: rtl/dict_pkg.sv
// Shared defaults, derived widths and FSM state encoding for the dictionary
// compressor scheduler.
package dict_pkg;

    localparam int DEF_CHUNK_SIZE    = 4;
    localparam int DEF_NUM_CHUNKS    = 8;
    localparam int DEF_CODEBOOK_SIZE = 8;
    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_TIMEOUT       = 64;

    localparam int DEF_STREAM_LEN = DEF_CHUNK_SIZE * DEF_NUM_CHUNKS;
    localparam int DEF_INDEX_BITS = $clog2(DEF_CODEBOOK_SIZE);
    localparam int DEF_OUT_W      = DEF_NUM_CHUNKS * DEF_INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND  = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        CLEAR = 3'd4
    } state_e;

endpackage

// File: rtl/dict_compress_scheduler_if.sv
// Requester, compressor and response signals of the scheduler; master is the
// scheduler side, slave is the requester/compressor environment.
interface dict_compress_scheduler_if #(
    parameter int NUM_REQ    = 4,
    parameter int STREAM_LEN = 32,
    parameter int OUT_W      = 24,
    parameter int ID_W       = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*STREAM_LEN-1:0] req_frame;
    logic [NUM_REQ-1:0]            gnt;
    logic                          comp_data_in;
    logic                          comp_data_valid;
    logic                          comp_clear;
    logic [OUT_W-1:0]              comp_out;
    logic                          comp_done;
    logic                          resp_valid;
    logic                          resp_ready;
    logic [ID_W-1:0]               resp_id;
    logic [OUT_W-1:0]              resp_data;
    logic                          resp_err;

    modport master (
        input  req, req_frame, comp_out, comp_done, resp_ready,
        output gnt, comp_data_in, comp_data_valid, comp_clear,
               resp_valid, resp_id, resp_data, resp_err
    );

    modport slave (
        output req, req_frame, comp_out, comp_done, resp_ready,
        input  gnt, comp_data_in, comp_data_valid, comp_clear,
               resp_valid, resp_id, resp_data, resp_err
    );
endinterface

// File: rtl/dict_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner, so the
// previous winner has lowest priority.
module dict_rr_arbiter
    import dict_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_id,
    output logic               o_any
);
    always_comb begin
        o_gnt = '0;
        o_id  = '0;
        o_any = 1'b0;
        // Walk from lowest to highest priority so the last hit wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            int idx;
            idx = (int'(i_last) + k) % NUM_REQ;
            if (i_req[idx]) begin
                o_any = 1'b1;
                o_id  = ID_W'(idx);
            end
        end
        if (o_any) o_gnt[o_id] = 1'b1;
    end
endmodule

// File: rtl/dict_compress_scheduler.sv
// Arbitrates frame requests and streams each winning frame MSB-first into the
// compressor, then returns the indices. Define DICT_SCHED_TIMEOUT_EN for a WAIT timeout.
module dict_compress_scheduler
    import dict_pkg::*;
#(
    parameter int CHUNK_SIZE    = DEF_CHUNK_SIZE,
    parameter int NUM_CHUNKS    = DEF_NUM_CHUNKS,
    parameter int CODEBOOK_SIZE = DEF_CODEBOOK_SIZE,
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input logic                       clk,
    input logic                       rst_n,
    dict_compress_scheduler_if.master bus
);
    localparam int STREAM_LEN = CHUNK_SIZE * NUM_CHUNKS;
    localparam int INDEX_BITS = $clog2(CODEBOOK_SIZE);
    localparam int OUT_W      = NUM_CHUNKS * INDEX_BITS;
    localparam int ID_W       = $clog2(NUM_REQ);
    localparam int CNT_W      = $clog2(STREAM_LEN);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_SEND  = SEND;
    localparam logic [2:0] ST_WAIT  = WAIT;
    localparam logic [2:0] ST_RESP  = RESP;
    localparam logic [2:0] ST_CLEAR = CLEAR;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    logic [2:0]            r_state;
    logic [CNT_W-1:0]      r_bcnt;
    logic [STREAM_LEN-1:0] r_shift;
    logic [ID_W-1:0]       r_id;
    logic [ID_W-1:0]       r_last;
    logic [OUT_W-1:0]      r_resp_data;

    logic [NUM_REQ-1:0]    w_gnt;
    logic [ID_W-1:0]       w_id;
    logic                  w_any;
    logic [STREAM_LEN-1:0] w_frames [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_frames
        assign w_frames[g] = bus.req_frame[g*STREAM_LEN +: STREAM_LEN];
    end

    dict_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .i_req  (bus.req),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_id   (w_id),
        .o_any  (w_any)
    );

`ifdef DICT_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_tcnt;
    logic            r_resp_err;
    assign bus.resp_err = r_resp_err;
`else
    assign bus.resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bcnt      <= '0;
            r_shift     <= '0;
            r_id        <= '0;
            r_last      <= ID_W'(NUM_REQ - 1);
            r_resp_data <= '0;
`ifdef DICT_SCHED_TIMEOUT_EN
            r_tcnt      <= '0;
            r_resp_err  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_shift <= w_frames[w_id];
                        r_id    <= w_id;
                        r_bcnt  <= '0;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_shift <= r_shift << 1;
                    r_bcnt  <= r_bcnt + CNT_W'(1);
                    if (r_bcnt == CNT_W'(STREAM_LEN - 1)) begin
                        r_bcnt  <= '0;
                        r_state <= ST_WAIT;
`ifdef DICT_SCHED_TIMEOUT_EN
                        r_tcnt  <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (bus.comp_done) begin
                        r_resp_data <= bus.comp_out;
                        r_state     <= ST_RESP;
`ifdef DICT_SCHED_TIMEOUT_EN
                        r_resp_err  <= 1'b0;
                    end else if (r_tcnt == TO_W'(TIMEOUT - 1)) begin
                        r_resp_data <= '0;
                        r_resp_err  <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_tcnt <= r_tcnt + TO_W'(1);
`endif
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) r_state <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    r_last  <= r_id;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Grant is combinational so the first data bit follows it by one cycle.
    assign bus.gnt             = (rst_n && r_state == ST_IDLE) ? w_gnt : '0;
    assign bus.comp_data_valid = (r_state == ST_SEND);
    assign bus.comp_data_in    = (r_state == ST_SEND) & r_shift[STREAM_LEN-1];
    assign bus.comp_clear      = !rst_n || (r_state == ST_CLEAR);
    assign bus.resp_valid      = (r_state == ST_RESP);
    assign bus.resp_id         = r_id;
    assign bus.resp_data       = r_resp_data;

endmodule

// File: tb/tb_dict_compress_scheduler.sv
// Directed + randomized bench for dict_compress_scheduler with a frame-level
// reference model; the timeout scenario follows DICT_SCHED_TIMEOUT_EN.
module tb_dict_compress_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   last_w = 3;

    always #5 clk = ~clk;

    dict_compress_scheduler_if bus ();

    dict_compress_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first active requester after the previous winner.
    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int s = 1; s <= 4; s++)
            if (r[(last + s) % 4]) return (last + s) % 4;
        return 0;
    endfunction

    // Called at a negedge with the DUT in IDLE; leaves it at a negedge in IDLE.
    // dd < 0 means the compressor never answers on its own.
    task automatic run_frame(input logic [3:0] rq, input int dd, input int rd,
                             input bit scramble, input bit use_dir,
                             input logic [31:0] dir_frame, input logic [23:0] dir_out);
        int exp_id, ewait;
        bit to_mode, eerr;
        logic [31:0] efr;
        logic [23:0] cout, edata;
        bus.req = rq;
        for (int i = 0; i < 4; i++) bus.req_frame[i*32 +: 32] = $urandom;
        if (use_dir) bus.req_frame[31:0] = dir_frame;
        cout = use_dir ? dir_out : 24'($urandom);
        #1;
        exp_id = rr_pick(rq, last_w);
        efr    = bus.req_frame[exp_id*32 +: 32];
        chk("gnt_onehot", bus.gnt, 64'(1) << exp_id);
        chk("idle_valid", bus.comp_data_valid, 0);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            chk("send_valid", bus.comp_data_valid, 1);
            chk("send_bit", bus.comp_data_in, efr[31-k]);
            chk("send_gnt", bus.gnt, 0);
            if (k == 0 && scramble) begin
                bus.req = 4'($urandom);
                for (int i = 0; i < 4; i++) bus.req_frame[i*32 +: 32] = $urandom;
            end
            if (k == 31) begin
                bus.comp_out  = cout;
                bus.comp_done = (dd == 0);
            end
        end
        to_mode = 1'b0;
        eerr    = 1'b0;
        edata   = cout;
        ewait   = dd;
        if (dd < 0) begin
`ifdef DICT_SCHED_TIMEOUT_EN
            to_mode = 1'b1;
            ewait   = 63;
            eerr    = 1'b1;
            edata   = '0;
`else
            ewait   = 99;
`endif
        end
        for (int w = 0; w <= ewait; w++) begin
            @(negedge clk);
            chk("wait_valid", bus.comp_data_valid, 0);
            chk("wait_resp_valid", bus.resp_valid, 0);
            chk("wait_gnt", bus.gnt, 0);
            if (w == ewait && !to_mode) bus.comp_done = 1'b1;
        end
        for (int r = 0; r <= rd; r++) begin
            @(negedge clk);
            chk("resp_valid", bus.resp_valid, 1);
            chk("resp_id", bus.resp_id, exp_id);
            chk("resp_data", bus.resp_data, edata);
            chk("resp_err", bus.resp_err, eerr);
            chk("resp_gnt", bus.gnt, 0);
            chk("resp_clear", bus.comp_clear, 0);
            bus.comp_done = 1'b0;
            bus.comp_out  = 24'($urandom);
            if (r == rd) bus.resp_ready = 1'b1;
        end
        @(negedge clk);
        chk("clear_pulse", bus.comp_clear, 1);
        chk("clear_resp_valid", bus.resp_valid, 0);
        chk("clear_gnt", bus.gnt, 0);
        bus.resp_ready = 1'b0;
        last_w = exp_id;
        @(negedge clk);
        chk("idle_clear_low", bus.comp_clear, 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req        = 4'hF;
        bus.req_frame  = '0;
        bus.comp_out   = '0;
        bus.comp_done  = 1'b0;
        bus.resp_ready = 1'b0;
        #3;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_valid", bus.comp_data_valid, 0);
        chk("rst_data_in", bus.comp_data_in, 0);
        chk("rst_clear", bus.comp_clear, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_err", bus.resp_err, 0);
        chk("rst_resp_id", bus.resp_id, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        repeat (2) @(negedge clk);
        chk("rst_hold_gnt", bus.gnt, 0);
        bus.req = '0;
        rst_n   = 1'b1;
        #1;
        chk("post_rst_clear", bus.comp_clear, 0);
        chk("post_rst_gnt", bus.gnt, 0);
        repeat (2) @(negedge clk);
        chk("idle_noreq_gnt", bus.gnt, 0);

        // Directed frame: known bit pattern, late done, stalled response.
        run_frame(4'b0001, 5, 3, 1'b0, 1'b1, 32'hA5C3_0F96, 24'h123456);

        // All requesters held: grants rotate.
        for (int n = 0; n < 5; n++) run_frame(4'b1111, n % 2, n % 3, 1'b0, 1'b0, '0, '0);

        // Idle gap with no requests.
        bus.req = '0;
        repeat (3) begin
            @(negedge clk);
            chk("gap_gnt", bus.gnt, 0);
            chk("gap_valid", bus.comp_data_valid, 0);
        end

        // Random request patterns, delays, and req changes mid-frame.
        for (int n = 0; n < 8; n++)
            run_frame(4'($urandom_range(1, 15)), int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 4)), 1'b1, 1'b0, '0, '0);

        // Compressor silent: timeout response, or indefinite wait.
        run_frame(4'b0010, -1, 1, 1'b0, 1'b0, '0, '0);

        // Reset in the middle of SEND aborts the frame.
        bus.req = 4'b0100;
        #1;
        chk("abort_gnt", bus.gnt, 64'(1) << rr_pick(4'b0100, last_w));
        repeat (11) @(negedge clk);
        chk("abort_pre_valid", bus.comp_data_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", bus.comp_data_valid, 0);
        chk("abort_clear", bus.comp_clear, 1);
        chk("abort_resp_valid", bus.resp_valid, 0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        last_w = 3;
        #1;
        chk("abort_rel_clear", bus.comp_clear, 0);
        chk("abort_rel_valid", bus.comp_data_valid, 0);
        chk("abort_rel_resp", bus.resp_valid, 0);
        run_frame(4'b0100, 2, 0, 1'b0, 1'b0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
